// File: rtl/adder_tree_pkg.sv
// Shared constants and FSM encodings for the adder-tree operand feeder and its result buffer.
package adder_tree_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_OPS   = 16;
    localparam int TREE_LAT  = 4;
    localparam int SUM_W     = 32;
    localparam int CNT_W     = 5;
    localparam int RES_DEPTH = 4;

    typedef logic [0:0] state_t;

    localparam state_t FILL = 1'b0;
    localparam state_t HOLD = 1'b1;

endpackage

// File: rtl/res_fifo_sync.sv
// Synchronous first-word-fall-through FIFO with registered head outputs and an occupancy count.
module res_fifo_sync #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);
    import adder_tree_pkg::*;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] head;
    logic             pop;
    logic             full;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop      = out_valid_q && out_ready;
        full     = (count_q == CW'(DEPTH));
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        // The word being pushed becomes the new head when it lands on the next read slot.
        head        = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        out_valid_d = (count_d != '0);
        out_data_d  = out_valid_d ? head : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && full && !pop));
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = count_q;

endmodule

// File: rtl/adder_tree_operand_feeder.sv
// Packs a word stream into zero-padded operand groups for the pipelined adder tree and
// buffers the realigned sums, launching only when a result slot is guaranteed.
module adder_tree_operand_feeder #(
    parameter int DATA_W    = adder_tree_pkg::DATA_W,
    parameter int NUM_OPS   = adder_tree_pkg::NUM_OPS,
    parameter int TREE_LAT  = adder_tree_pkg::TREE_LAT,
    parameter int SUM_W     = adder_tree_pkg::SUM_W,
    parameter int RES_DEPTH = adder_tree_pkg::RES_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_last,
    output logic [NUM_OPS*DATA_W-1:0]   ops_flat,
    input  logic [SUM_W-1:0]            tree_sum,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [SUM_W-1:0]            res_data,
    output logic [adder_tree_pkg::CNT_W-1:0] res_count
);
    import adder_tree_pkg::*;

    localparam int FIFO_CW = $clog2(RES_DEPTH + 1);
    localparam int FIFO_W  = SUM_W + CNT_W;

    state_t                             state_q, state_d;
    logic                               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [NUM_OPS-1:0][DATA_W-1:0]     fill_q, fill_d;
    logic [CNT_W-1:0]                   tag_hold_q, tag_hold_d;
    logic [NUM_OPS-1:0][DATA_W-1:0]     ops_q, ops_d;
    logic [TREE_LAT:0]                  vld_pipe_q, vld_pipe_d;
    logic [TREE_LAT:0][CNT_W-1:0]       tag_pipe_q, tag_pipe_d;

    logic [NUM_OPS-1:0][DATA_W-1:0]     grp;
    logic                               accept;
    logic                               complete;
    logic                               credit_ok;
    logic [CNT_W-1:0]                   in_flight;
    logic                               launch;
    logic [CNT_W-1:0]                   launch_tag;
    logic [FIFO_CW-1:0]                 fifo_count;
    logic [FIFO_W-1:0]                  fifo_out;

    function automatic logic [CNT_W-1:0] ones_count(input logic [TREE_LAT:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i <= TREE_LAT; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Group as it would look if the current word closes it: later slots read as zero.
    always_comb begin
        grp = fill_q;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (CNT_W'(k) == cnt_q) begin
                grp[k] = in_data;
            end else if (CNT_W'(k) > cnt_q) begin
                grp[k] = '0;
            end
        end
    end

    always_comb begin
        accept    = in_valid && in_ready_q;
        complete  = accept && (in_last || (cnt_q == CNT_W'(NUM_OPS - 1)));
        // Results still in the tree count against the FIFO; a pop this cycle does not.
        in_flight = ones_count(vld_pipe_q) + CNT_W'(fifo_count);
        credit_ok = (in_flight < CNT_W'(RES_DEPTH));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        tag_hold_d = tag_hold_q;
        ops_d      = ops_q;
        launch     = 1'b0;
        launch_tag = '0;
        case (state_q)
            FILL: begin
                if (complete) begin
                    cnt_d = '0;
                    if (credit_ok) begin
                        ops_d      = grp;
                        launch     = 1'b1;
                        launch_tag = cnt_q + CNT_W'(1);
                    end else begin
                        fill_d     = grp;
                        tag_hold_d = cnt_q + CNT_W'(1);
                        state_d    = HOLD;
                    end
                end else if (accept) begin
                    for (int k = 0; k < NUM_OPS; k++) begin
                        if (CNT_W'(k) == cnt_q) begin
                            fill_d[k] = in_data;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (credit_ok) begin
                    ops_d      = fill_q;
                    launch     = 1'b1;
                    launch_tag = tag_hold_q;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d = (state_d == FILL);
    end

    always_comb begin
        vld_pipe_d    = {vld_pipe_q[TREE_LAT-1:0], launch};
        tag_pipe_d    = tag_pipe_q;
        tag_pipe_d[0] = launch_tag;
        for (int i = 1; i <= TREE_LAT; i++) begin
            tag_pipe_d[i] = tag_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            fill_q     <= '0;
            ops_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            ops_q      <= ops_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_hold_q <= tag_hold_d;
        tag_pipe_q <= tag_pipe_d;
    end

    // The tree output lines up with vld_pipe_q[TREE_LAT]; capture it on the following edge.
    res_fifo_sync #(
        .WIDTH (FIFO_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_pipe_q[TREE_LAT]),
        .push_data ({tree_sum, tag_pipe_q[TREE_LAT]}),
        .out_valid (res_valid),
        .out_ready (res_ready),
        .out_data  (fifo_out),
        .count     (fifo_count)
    );

    assign in_ready  = in_ready_q;
    assign ops_flat  = ops_q;
    assign res_data  = fifo_out[FIFO_W-1:CNT_W];
    assign res_count = fifo_out[CNT_W-1:0];

endmodule

// File: tb/tb_adder_tree_operand_feeder.sv
// Bench for the operand feeder driving a 4-stage pairwise adder tree built alongside it.
module tb_adder_tree_operand_feeder;
    localparam int DW = 16;
    localparam int NO = 16;
    localparam int SW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_last = 1'b0;
    logic              res_ready = 1'b1;
    logic [DW-1:0]     in_data = '0;
    logic              in_ready;
    logic              res_valid;
    logic [NO*DW-1:0]  ops_flat;
    logic [SW-1:0]     tree_sum;
    logic [SW-1:0]     res_data;
    logic [4:0]        res_count;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  cnt;
        int unsigned cyc;
    } rx_t;
    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  cnt;
    } exp_t;

    rx_t  rx_q[$];
    exp_t exp_q[$];
    bit   rnd_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    adder_tree_operand_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .ops_flat  (ops_flat),
        .tree_sum  (tree_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_count (res_count)
    );

    // Pairwise adder tree, one register level per stage, no reset.
    logic [SW-1:0] t1_q [8];
    logic [SW-1:0] t2_q [4];
    logic [SW-1:0] t3_q [2];
    logic [SW-1:0] t4_q;
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) t1_q[i] <= SW'(ops_flat[2*i*DW +: DW]) + SW'(ops_flat[(2*i+1)*DW +: DW]);
        for (int i = 0; i < 4; i++) t2_q[i] <= t1_q[2*i] + t1_q[2*i+1];
        for (int i = 0; i < 2; i++) t3_q[i] <= t2_q[2*i] + t2_q[2*i+1];
        t4_q <= t3_q[0] + t3_q[1];
    end
    assign tree_sum = t4_q;

    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) rx_q.push_back('{res_data, res_count, cyc});
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_word(input logic [15:0] d, input logic last, output int unsigned acc_edge);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_word: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        acc_edge = cyc + 1;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_group(input logic [15:0] words[$], input logic last_on_end, output int unsigned acc_edge);
        for (int i = 0; i < words.size(); i++)
            send_word(words[i], last_on_end && (i == words.size() - 1), acc_edge);
    endtask

    task automatic wait_rx(input int n, input int bound);
        int k;
        k = 0;
        while (rx_q.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%0b want=0", res_valid); end
        checks++; if (ops_flat !== '0) begin errors++; $display("FAIL reset_ops_flat got=%0h want=0", ops_flat); end
        checks++; if (res_data !== 32'd0) begin errors++; $display("FAIL reset_res_data got=%0h want=0", res_data); end
        checks++; if (res_count !== 5'd0) begin errors++; $display("FAIL reset_res_count got=%0d want=0", res_count); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_full_group();
        logic [15:0] w[$];
        int unsigned acc;
        rx_q.delete();
        for (int i = 1; i <= 16; i++) w.push_back(16'(i));
        send_group(w, 1'b1, acc);
        idle();
        wait_rx(1, 50);
        checks++;
        if (rx_q.size() !== 1) begin
            errors++;
            $display("FAIL full_group_count got=%0d results want=1", rx_q.size());
        end else begin
            checks++; if (rx_q[0].data !== 32'd136) begin errors++; $display("FAIL full_group_sum got=%0d want=136", rx_q[0].data); end
            checks++; if (rx_q[0].cnt !== 5'd16) begin errors++; $display("FAIL full_group_cnt got=%0d want=16", rx_q[0].cnt); end
            checks++; if (rx_q[0].cyc - acc !== 5) begin errors++; $display("FAIL full_group_latency got=%0d want=5", rx_q[0].cyc - acc); end
        end
        repeat (10) @(negedge clk);
        checks++; if (rx_q.size() !== 1) begin errors++; $display("FAIL repeat_sums_ignored got=%0d results want=1", rx_q.size()); end
    endtask

    task automatic test_partial_and_max();
        logic [15:0] w[$];
        int unsigned acc;
        rx_q.delete();
        w = '{16'd100, 16'd200, 16'd300};
        send_group(w, 1'b1, acc);
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(16'hFFFF);
        send_group(w, 1'b0, acc);
        idle();
        wait_rx(2, 60);
        checks++;
        if (rx_q.size() !== 2) begin
            errors++;
            $display("FAIL partial_count got=%0d results want=2", rx_q.size());
        end else begin
            checks++; if (rx_q[0].data !== 32'd600) begin errors++; $display("FAIL partial_sum got=%0d want=600", rx_q[0].data); end
            checks++; if (rx_q[0].cnt !== 5'd3) begin errors++; $display("FAIL partial_cnt got=%0d want=3", rx_q[0].cnt); end
            checks++; if (rx_q[1].data !== 32'h000FFFF0) begin errors++; $display("FAIL max_sum got=%0h want=000ffff0", rx_q[1].data); end
            checks++; if (rx_q[1].cnt !== 5'd16) begin errors++; $display("FAIL max_cnt got=%0d want=16", rx_q[1].cnt); end
        end
    endtask

    task automatic test_back_to_back();
        rx_q.delete();
        @(negedge clk);
        res_ready = 1'b0;
        fork
            begin
                logic [15:0] w[$];
                int unsigned acc;
                for (int i = 0; i < 16; i++) w.push_back(16'd1);
                for (int g = 0; g < 6; g++) send_group(w, 1'b0, acc);
                idle();
            end
            begin
                repeat (110) @(negedge clk);
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready got=%0b want=0", in_ready); end
                checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL hold_res_valid got=%0b want=1", res_valid); end
                checks++; if (res_data !== 32'd16) begin errors++; $display("FAIL hold_head_sum got=%0d want=16", res_data); end
                checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL hold_no_pop got=%0d results want=0", rx_q.size()); end
                res_ready = 1'b1;
            end
        join
        wait_rx(6, 200);
        checks++;
        if (rx_q.size() !== 6) begin
            errors++;
            $display("FAIL backpressure_count got=%0d results want=6", rx_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (rx_q[i].data !== 32'd16 || rx_q[i].cnt !== 5'd16) begin
                    errors++;
                    $display("FAIL backpressure_result[%0d] got sum=%0d cnt=%0d want sum=16 cnt=16", i, rx_q[i].data, rx_q[i].cnt);
                end
            end
        end
    endtask

    task automatic test_single_word();
        int unsigned acc;
        rx_q.delete();
        send_word(16'd7, 1'b1, acc);
        idle();
        wait_rx(1, 30);
        checks++;
        if (rx_q.size() !== 1) begin
            errors++;
            $display("FAIL single_count got=%0d results want=1", rx_q.size());
        end else begin
            checks++; if (rx_q[0].data !== 32'd7) begin errors++; $display("FAIL single_sum got=%0d want=7", rx_q[0].data); end
            checks++; if (rx_q[0].cnt !== 5'd1) begin errors++; $display("FAIL single_cnt got=%0d want=1", rx_q[0].cnt); end
        end
    endtask

    task automatic test_reset_midstream();
        logic [15:0] w[$];
        int unsigned acc;
        rx_q.delete();
        for (int i = 0; i < 9; i++) w.push_back(16'd3);
        send_group(w, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midreset_in_ready got=%0b want=0", in_ready); end
        checks++; if (ops_flat !== '0) begin errors++; $display("FAIL midreset_ops_flat got=%0h want=0", ops_flat); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL partial_dropped got=%0d results want=0", rx_q.size()); end
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(16'd5);
        send_group(w, 1'b0, acc);
        idle();
        do_reset();
        repeat (20) @(negedge clk);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL inflight_dropped got=%0d results want=0", rx_q.size()); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL inflight_res_valid got=%0b want=0", res_valid); end
        w.delete();
        for (int i = 0; i < 16; i++) w.push_back(16'd2);
        send_group(w, 1'b0, acc);
        idle();
        wait_rx(1, 50);
        checks++;
        if (rx_q.size() !== 1) begin
            errors++;
            $display("FAIL after_reset_count got=%0d results want=1", rx_q.size());
        end else begin
            checks++; if (rx_q[0].data !== 32'd32) begin errors++; $display("FAIL after_reset_sum got=%0d want=32", rx_q[0].data); end
            checks++; if (rx_q[0].cnt !== 5'd16) begin errors++; $display("FAIL after_reset_cnt got=%0d want=16", rx_q[0].cnt); end
        end
    endtask

    task automatic test_random();
        rx_q.delete();
        exp_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                for (int g = 0; g < 1000; g++) begin
                    int len;
                    logic [31:0] sum;
                    logic last_flag;
                    int unsigned acc;
                    if (rnd_done) break;
                    len = $urandom_range(1, 16);
                    last_flag = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
                    sum = '0;
                    for (int i = 0; i < len; i++) begin
                        logic [15:0] d;
                        int gap;
                        d = 16'($urandom);
                        sum = sum + 32'(d);
                        if (i == len - 1) exp_q.push_back('{sum, 5'(len)});
                        gap = $urandom_range(0, 2);
                        if (gap > 0) begin
                            @(negedge clk);
                            in_valid = 1'b0;
                            in_last  = 1'b0;
                            repeat (gap - 1) @(negedge clk);
                        end
                        send_word(d, last_flag && (i == len - 1), acc);
                    end
                end
                idle();
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    res_ready = ($urandom_range(0, 3) != 0);
                end
                res_ready = 1'b1;
            end
            begin
                int got;
                int k;
                got = 0;
                k = 0;
                while (got < 1000 && k < 60000) begin
                    @(negedge clk);
                    k++;
                    while (rx_q.size() > 0 && exp_q.size() > 0) begin
                        rx_t  r;
                        exp_t e;
                        r = rx_q.pop_front();
                        e = exp_q.pop_front();
                        got++;
                        checks++;
                        if (r.data !== e.data || r.cnt !== e.cnt) begin
                            errors++;
                            $display("FAIL rand_result[%0d] got sum=%0h cnt=%0d want sum=%0h cnt=%0d",
                                     got - 1, r.data, r.cnt, e.data, e.cnt);
                        end
                    end
                end
                checks++;
                if (got !== 1000) begin
                    errors++;
                    $display("FAIL rand_total got=%0d results want=1000", got);
                end
                rnd_done = 1'b1;
            end
        join
    endtask

    initial begin
        test_reset();
        test_full_group();
        test_partial_and_max();
        test_back_to_back();
        test_single_word();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
